// File: rtl/d3s_pkg.sv
// Shared timestamp types and helpers for the D3S receive path.
// A timestamp is {tai seconds, 8 ns cycles}. Time order is lexicographic on that pair.
package d3s_pkg;

    localparam int unsigned c_cycles_per_sec = 125000000;
    localparam int unsigned c_phase_bits     = 14;
    localparam int unsigned c_ts_bits        = 60;

    typedef struct packed {
        logic [31:0] tai;
        logic [27:0] cycles;
    } d3s_ts_t;

    // Add a cycle offset to a timestamp.
    // A single wrap into the next second is enough because the offset is always below one second.
    function automatic d3s_ts_t f_ts_add_cycles(input d3s_ts_t ts,
                                                input logic [27:0] add,
                                                input logic [27:0] cps);
        logic [28:0] sum;
        d3s_ts_t     res;
        sum = {1'b0, ts.cycles} + {1'b0, add};
        if (sum >= {1'b0, cps}) begin
            res.cycles = 28'(sum - {1'b0, cps});
            res.tai    = ts.tai + 32'd1;
        end else begin
            res.cycles = sum[27:0];
            res.tai    = ts.tai;
        end
        return res;
    endfunction

    // Strictly earlier: the seconds are smaller, or the seconds are equal and the cycles are smaller.
    function automatic logic f_ts_less(input d3s_ts_t a, input d3s_ts_t b);
        logic res;
        if (a.tai < b.tai) begin
            res = 1'b1;
        end else if (a.tai == b.tai) begin
            res = (a.cycles < b.cycles);
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    function automatic logic f_ts_equal(input d3s_ts_t a, input d3s_ts_t b);
        return (a.tai == b.tai) && (a.cycles == b.cycles);
    endfunction

endpackage

// File: rtl/d3s_ts_fifo.sv
// Generic synchronous FIFO with first-word fall-through read data and a flush input.
// Full is judged on the registered count, so a push into a full FIFO is refused
// even if a pop happens in the same cycle. Flush takes priority over push and pop.
module d3s_ts_fifo #(
    parameter int unsigned g_width      = 74,
    parameter int unsigned g_depth_log2 = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [g_width-1:0]      din_i,
    output logic [g_width-1:0]      dout_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [g_depth_log2:0]   count_o
);

    localparam int unsigned c_depth = 2 ** g_depth_log2;
    localparam int unsigned c_cw    = g_depth_log2 + 1;

    logic [g_width-1:0]      mem_r [0:c_depth-1];
    logic [g_depth_log2-1:0] wr_ptr_r;
    logic [g_depth_log2-1:0] rd_ptr_r;
    logic [g_depth_log2:0]   count_r;
    logic                    push_ok_s;
    logic                    pop_ok_s;

    assign full_o    = (count_r == c_cw'(c_depth));
    assign empty_o   = (count_r == c_cw'(0));
    assign push_ok_s = push_i && !full_o && !flush_i;
    assign pop_ok_s  = pop_i && !empty_o && !flush_i;
    assign dout_o    = mem_r[rd_ptr_r];
    assign count_o   = count_r;

    // Storage array; it needs no reset because the pointers and the count decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping, with flush returning the FIFO to empty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + g_depth_log2'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + g_depth_log2'(1);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + c_cw'(1);
            end else if (!push_ok_s && pop_ok_s) begin
                count_r <= count_r - c_cw'(1);
            end
        end
    end

endmodule

// File: rtl/d3s_phase_playback.sv
// Receive-side elastic buffer. It holds timestamped phase samples until local WR time
// reaches the sample timestamp plus the reception delay. It then releases each sample,
// bias-corrected, to the upsampler.
module d3s_phase_playback
    import d3s_pkg::*;
#(
    parameter int unsigned g_fifo_depth_log2 = 4,
    parameter int unsigned g_cycles_per_sec  = 125000000,
    parameter int unsigned g_phase_bits      = 14
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        rx_valid_i,
    input  logic [31:0]                 rx_ts_tai_i,
    input  logic [27:0]                 rx_ts_cycles_i,
    input  logic [g_phase_bits-1:0]     rx_phase_i,
    input  logic [27:0]                 rec_delay_cycles_i,
    input  logic [g_phase_bits-1:0]     rec_delay_bias_i,
    input  logic                        tm_time_valid_i,
    input  logic [31:0]                 tm_tai_i,
    input  logic [27:0]                 tm_cycles_i,
    output logic                        phase_valid_o,
    output logic [31:0]                 phase_ts_tai_o,
    output logic [27:0]                 phase_ts_cycles_o,
    output logic [g_phase_bits-1:0]     phase_o,
    output logic [g_fifo_depth_log2:0]  fifo_count_o,
    output logic [15:0]                 overflow_cnt_o,
    output logic [15:0]                 late_cnt_o
);

    localparam int unsigned c_entry_w = c_ts_bits + g_phase_bits;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;

    logic                     wr_valid_r;
    d3s_ts_t                  wr_ts_r;
    logic [g_phase_bits-1:0]  wr_phase_r;
    d3s_ts_t                  rx_ts_s;

    logic [c_entry_w-1:0]     fifo_din_s;
    logic [c_entry_w-1:0]     fifo_dout_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [g_fifo_depth_log2:0] fifo_count_s;

    d3s_ts_t                  head_ts_s;
    logic [g_phase_bits-1:0]  head_phase_s;
    d3s_ts_t                  now_ts_s;

    logic                     flush_s;
    logic                     pop_s;
    logic                     release_s;
    logic                     late_s;

    logic                     phase_valid_r;
    logic [31:0]              phase_ts_tai_r;
    logic [27:0]              phase_ts_cycles_r;
    logic [g_phase_bits-1:0]  phase_r;
    logic [15:0]              overflow_cnt_r;
    logic [15:0]              late_cnt_r;

    assign rx_ts_s      = '{tai: rx_ts_tai_i, cycles: rx_ts_cycles_i};
    assign now_ts_s     = '{tai: tm_tai_i, cycles: tm_cycles_i};
    assign fifo_din_s   = {wr_ts_r, wr_phase_r};
    assign head_ts_s    = fifo_dout_s[c_entry_w-1 -: c_ts_bits];
    assign head_phase_s = fifo_dout_s[g_phase_bits-1:0];

    // Write stage: turn the sample timestamp into its release time, one cycle ahead of the push.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_valid_r <= 1'b0;
            wr_ts_r    <= '0;
            wr_phase_r <= '0;
        end else begin
            wr_valid_r <= rx_valid_i;
            if (rx_valid_i) begin
                wr_ts_r    <= f_ts_add_cycles(rx_ts_s, rec_delay_cycles_i, 28'(g_cycles_per_sec));
                wr_phase_r <= rx_phase_i;
            end
        end
    end

    d3s_ts_fifo #(
        .g_width      (c_entry_w),
        .g_depth_log2 (g_fifo_depth_log2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_s),
        .push_i  (wr_valid_r),
        .pop_i   (pop_s),
        .din_i   (fifo_din_s),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Playback state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and pop decision: release on an exact time match, discard if the head is already past.
    always_comb begin
        state_next_s = state_r;
        flush_s      = 1'b0;
        pop_s        = 1'b0;
        release_s    = 1'b0;
        late_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                flush_s = 1'b1;
                if (tm_time_valid_i) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!tm_time_valid_i) begin
                    flush_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (fifo_empty_s) begin
                    state_next_s = ST_WAIT;
                end else if (f_ts_equal(head_ts_s, now_ts_s)) begin
                    pop_s     = 1'b1;
                    release_s = 1'b1;
                end else if (f_ts_less(head_ts_s, now_ts_s)) begin
                    pop_s  = 1'b1;
                    late_s = 1'b1;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                flush_s      = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output stage: a one-cycle strobe with the release time, and the biased phase held until the next release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_valid_r     <= 1'b0;
            phase_ts_tai_r    <= '0;
            phase_ts_cycles_r <= '0;
            phase_r           <= '0;
        end else begin
            phase_valid_r <= release_s;
            if (release_s) begin
                phase_ts_tai_r    <= head_ts_s.tai;
                phase_ts_cycles_r <= head_ts_s.cycles;
                phase_r           <= head_phase_s + rec_delay_bias_i;
            end
        end
    end

    // Saturating diagnostics: samples refused by a full FIFO, and samples that arrived too late to play.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_cnt_r <= '0;
            late_cnt_r     <= '0;
        end else begin
            if (wr_valid_r && fifo_full_s && !flush_s && (overflow_cnt_r != 16'hFFFF)) begin
                overflow_cnt_r <= overflow_cnt_r + 16'd1;
            end
            if (late_s && (late_cnt_r != 16'hFFFF)) begin
                late_cnt_r <= late_cnt_r + 16'd1;
            end
        end
    end

    assign phase_valid_o     = phase_valid_r;
    assign phase_ts_tai_o    = phase_ts_tai_r;
    assign phase_ts_cycles_o = phase_ts_cycles_r;
    assign phase_o           = phase_r;
    assign fifo_count_o      = fifo_count_s;
    assign overflow_cnt_o    = overflow_cnt_r;
    assign late_cnt_o        = late_cnt_r;

endmodule

// File: tb/tb_d3s_phase_playback.sv
// Directed bench for d3s_phase_playback. Local WR time is driven directly by the bench,
// and the expected values are computed by hand from the release-time arithmetic.
module tb_d3s_phase_playback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [31:0] rx_tai;
    logic [27:0] rx_cyc;
    logic [13:0] rx_phase;
    logic [27:0] delay;
    logic [13:0] bias;
    logic        tm_valid;
    logic [31:0] tm_tai;
    logic [27:0] tm_cyc;
    logic        phase_valid;
    logic [31:0] phase_tai;
    logic [27:0] phase_cyc;
    logic [13:0] phase;
    logic [4:0]  fifo_count;
    logic [15:0] ovf_cnt;
    logic [15:0] late_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    d3s_phase_playback dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .rx_valid_i         (rx_valid),
        .rx_ts_tai_i        (rx_tai),
        .rx_ts_cycles_i     (rx_cyc),
        .rx_phase_i         (rx_phase),
        .rec_delay_cycles_i (delay),
        .rec_delay_bias_i   (bias),
        .tm_time_valid_i    (tm_valid),
        .tm_tai_i           (tm_tai),
        .tm_cycles_i        (tm_cyc),
        .phase_valid_o      (phase_valid),
        .phase_ts_tai_o     (phase_tai),
        .phase_ts_cycles_o  (phase_cyc),
        .phase_o            (phase),
        .fifo_count_o       (fifo_count),
        .overflow_cnt_o     (ovf_cnt),
        .late_cnt_o         (late_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tm(input logic [31:0] tai, input logic [27:0] cyc);
        tm_tai = tai;
        tm_cyc = cyc;
    endtask

    task automatic send(input logic [31:0] tai, input logic [27:0] cyc, input logic [13:0] ph);
        rx_valid = 1'b1;
        rx_tai   = tai;
        rx_cyc   = cyc;
        rx_phase = ph;
        clk1();
        rx_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_tai   = 32'd0;
        rx_cyc   = 28'd0;
        rx_phase = 14'd0;
        delay    = 28'd500;
        bias     = 14'h0010;
        tm_valid = 1'b0;
        tm_tai   = 32'd0;
        tm_cyc   = 28'd0;
        #12;
        chk("rst_valid", phase_valid, 1'b0);
        chk("rst_tai",   phase_tai, 32'd0);
        chk("rst_cyc",   phase_cyc, 28'd0);
        chk("rst_phase", phase, 14'd0);
        chk("rst_count", fifo_count, 5'd0);
        chk("rst_ovf",   ovf_cnt, 16'd0);
        chk("rst_late",  late_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tm_valid = 1'b1;
        set_tm(32'd10, 28'd0);
        clk1();
        clk1();

        // Basic release: (10,1000)+500 -> (10,1500), phase 0x100+0x10
        send(32'd10, 28'd1000, 14'h0100);
        clk1();
        chk("b_count1", fifo_count, 5'd1);
        set_tm(32'd10, 28'd1499);
        clk1();
        chk("b_early_valid", phase_valid, 1'b0);
        chk("b_early_count", fifo_count, 5'd1);
        set_tm(32'd10, 28'd1500);
        clk1();
        chk("b_valid", phase_valid, 1'b1);
        chk("b_tai",   phase_tai, 32'd10);
        chk("b_cyc",   phase_cyc, 28'd1500);
        chk("b_phase", phase, 14'h0110);
        chk("b_count0", fifo_count, 5'd0);
        set_tm(32'd10, 28'd1501);
        clk1();
        chk("b_strobe_end", phase_valid, 1'b0);
        chk("b_phase_hold", phase, 14'h0110);

        // Second wrap: (20,124999900)+200 -> (21,100)
        delay = 28'd200;
        set_tm(32'd20, 28'd124999990);
        send(32'd20, 28'd124999900, 14'h0200);
        clk1();
        set_tm(32'd20, 28'd124999999);
        clk1();
        chk("w_pre1", phase_valid, 1'b0);
        set_tm(32'd21, 28'd0);
        clk1();
        chk("w_pre2", phase_valid, 1'b0);
        set_tm(32'd21, 28'd99);
        clk1();
        chk("w_pre3", phase_valid, 1'b0);
        chk("w_pending", fifo_count, 5'd1);
        set_tm(32'd21, 28'd100);
        clk1();
        chk("w_valid", phase_valid, 1'b1);
        chk("w_tai",   phase_tai, 32'd21);
        chk("w_cyc",   phase_cyc, 28'd100);
        chk("w_phase", phase, 14'h0210);
        delay = 28'd500;

        // Phase wrap: 0x3FF0 + 0x0020 -> 0x0010
        bias = 14'h0020;
        set_tm(32'd30, 28'd0);
        send(32'd30, 28'd0, 14'h3FF0);
        clk1();
        set_tm(32'd30, 28'd500);
        clk1();
        chk("p_valid", phase_valid, 1'b1);
        chk("p_phase", phase, 14'h0010);

        // Late discard: release (40,995) while local time is (40,1000)
        set_tm(32'd40, 28'd1000);
        send(32'd40, 28'd495, 14'h0055);
        clk1();
        chk("l_count1", fifo_count, 5'd1);
        chk("l_novalid1", phase_valid, 1'b0);
        clk1();
        chk("l_count0", fifo_count, 5'd0);
        chk("l_late", late_cnt, 16'd1);
        chk("l_novalid2", phase_valid, 1'b0);
        send(32'd40, 28'd2000, 14'h0077);
        clk1();
        set_tm(32'd40, 28'd2500);
        clk1();
        chk("l_next_valid", phase_valid, 1'b1);
        chk("l_next_phase", phase, 14'h0097);
        chk("l_late_keep", late_cnt, 16'd1);

        // Overflow: 17 back-to-back samples released at (60, 500+10*i)
        set_tm(32'd50, 28'd0);
        for (int i = 0; i < 17; i++) begin
            send(32'd60, 28'(i * 10), 14'(i));
        end
        clk1();
        chk("o_count", fifo_count, 5'd16);
        chk("o_ovf",   ovf_cnt, 16'd1);
        for (int i = 0; i < 16; i++) begin
            set_tm(32'd60, 28'(500 + i * 10));
            clk1();
            chk("o_rel_valid", phase_valid, 1'b1);
            chk("o_rel_cyc",   phase_cyc, 28'(500 + i * 10));
            chk("o_rel_phase", phase, 14'(i + 32));
        end
        chk("o_drained", fifo_count, 5'd0);

        // Time loss flushes the queue without strobes and keeps the counters
        set_tm(32'd70, 28'd0);
        for (int i = 0; i < 5; i++) begin
            send(32'd71, 28'(i), 14'(i + 1));
        end
        clk1();
        chk("t_count5", fifo_count, 5'd5);
        tm_valid = 1'b0;
        clk1();
        chk("t_flushed", fifo_count, 5'd0);
        chk("t_novalid1", phase_valid, 1'b0);
        tm_valid = 1'b1;
        clk1();
        chk("t_novalid2", phase_valid, 1'b0);
        clk1();
        chk("t_count0", fifo_count, 5'd0);
        chk("t_novalid3", phase_valid, 1'b0);
        chk("t_late_keep", late_cnt, 16'd1);
        chk("t_ovf_keep",  ovf_cnt, 16'd1);
        chk("t_phase_keep", phase, 14'h002F);

        // Asynchronous reset in mid-cycle clears outputs without waiting for a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_phase", phase, 14'd0);
        chk("r_tai",   phase_tai, 32'd0);
        chk("r_cyc",   phase_cyc, 28'd0);
        chk("r_ovf",   ovf_cnt, 16'd0);
        chk("r_late",  late_cnt, 16'd0);
        chk("r_count", fifo_count, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clk1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
